// File: rtl/hc154_pkg.sv
// Shared types and sizes for the hc154 4-to-16 line decoder.
package hc154_pkg;

  localparam int NUM_LINES = 16;
  localparam int CODE_W    = 4;
  localparam int DWELL_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    BLANK = 2'd2,
    SCAN  = 2'd3
  } state_e;

endpackage

// File: rtl/hc154_line_decoder_dec4to16_n.sv
// Combinational 4-to-16 decoder with active-low one-hot output and enable.
module dec4to16_n
  import hc154_pkg::*;
(
  input  logic [CODE_W-1:0]    code_i,
  input  logic                 en_i,
  output logic [NUM_LINES-1:0] line_n_o
);

  always_comb begin
    line_n_o = '1;
    if (en_i) begin
      line_n_o = ~(NUM_LINES'(1) << code_i);
    end
  end

endmodule

// File: rtl/hc154_line_decoder.sv
// Registered 74HC154-style line decoder: direct (valid/ready) and scan modes,
// with a one-cycle all-high blank between every line change.
module hc154_line_decoder
  import hc154_pkg::*;
#(
  parameter int DWELL_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 EN_N,
  input  logic                 mode,
  input  logic [CODE_W-1:0]    code,
  input  logic                 code_valid,
  output logic                 code_ready,
  output logic [NUM_LINES-1:0] out_N,
  output logic [CODE_W-1:0]    cur_code,
  output logic                 wrap,
  output state_e               dbg_state_o
);

  if (DWELL_CYCLES < 1 || DWELL_CYCLES > 255) begin : g_bad_dwell
    $error("hc154_line_decoder: DWELL_CYCLES must be in 1..255");
  end

  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [DWELL_W-1:0]     cnt_q, cnt_d;
  logic [CODE_W-1:0]      cur_q, cur_d;
  logic [NUM_LINES-1:0]   out_q, out_d;
  logic                   wrap_q, wrap_d;
  // Set while the current/last line came from scanning, so BLANK knows
  // whether to advance the index or start a fresh sweep at line 0.
  logic                   scan_q, scan_d;
  logic                   drive_d;

  // Handshake: a code transfers on a rising edge where code_valid and
  // code_ready are both high; code_ready depends only on registered state,
  // mode and EN_N, never on code_valid.
  assign code_ready = (state_q == IDLE) & ~mode & ~EN_N;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    wrap_d  = 1'b0;
    scan_d  = scan_q;
    if (EN_N) begin
      state_d = IDLE;
      cnt_d   = '0;
      cur_d   = '0;
      scan_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mode) begin
            state_d = SCAN;
            cur_d   = '0;
            cnt_d   = DWELL_LOAD;
            scan_d  = 1'b1;
          end else if (code_valid) begin
            state_d = HOLD;
            cur_d   = code;
            cnt_d   = DWELL_LOAD;
            scan_d  = 1'b0;
          end
        end
        HOLD, SCAN: begin
          if (cnt_q == '0) begin
            state_d = BLANK;
          end else begin
            cnt_d = cnt_q - DWELL_W'(1);
          end
        end
        BLANK: begin
          if (mode) begin
            state_d = SCAN;
            cnt_d   = DWELL_LOAD;
            scan_d  = 1'b1;
            if (scan_q) begin
              cur_d  = cur_q + CODE_W'(1);
              wrap_d = (cur_q == CODE_W'(NUM_LINES - 1));
            end else begin
              cur_d = '0;
            end
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign drive_d = (state_d == HOLD) || (state_d == SCAN);

  dec4to16_n u_dec (
    .code_i   (cur_d),
    .en_i     (drive_d),
    .line_n_o (out_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      out_q   <= '1;
      wrap_q  <= 1'b0;
      scan_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      out_q   <= out_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
    end
  end

  assign out_N       = out_q;
  assign cur_code    = cur_q;
  assign wrap        = wrap_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hc154_line_decoder.sv
// Bench for hc154_line_decoder: two instances (dwell 4 and dwell 1) share
// stimulus and are checked every cycle against a timeline model.
module tb_hc154_line_decoder;
  import hc154_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_n;
  logic        mode;
  logic [3:0]  code;
  logic        code_valid;

  logic        d_ready[2];
  logic [15:0] d_out[2];
  logic [3:0]  d_cur[2];
  logic        d_wrap[2];
  state_e      d_state[2];

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  hc154_line_decoder #(.DWELL_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .EN_N(en_n), .mode(mode), .code(code),
    .code_valid(code_valid), .code_ready(d_ready[0]), .out_N(d_out[0]),
    .cur_code(d_cur[0]), .wrap(d_wrap[0]), .dbg_state_o(d_state[0])
  );

  hc154_line_decoder #(.DWELL_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .EN_N(en_n), .mode(mode), .code(code),
    .code_valid(code_valid), .code_ready(d_ready[1]), .out_N(d_out[1]),
    .cur_code(d_cur[1]), .wrap(d_wrap[1]), .dbg_state_o(d_state[1])
  );

  // ---------------- reference model ----------------
  // Each active line is a timeline: el = 0..dwell-1 line low, el = dwell blank.
  int         dwell[2] = '{4, 1};
  int         m_el[2];
  bit         m_busy[2];
  bit         m_scan[2];
  bit         m_wrap[2];
  logic [3:0] m_line[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_el[i] = 0; m_busy[i] = 0; m_scan[i] = 0; m_wrap[i] = 0; m_line[i] = 0;
    end
  endtask

  task automatic model_start(int i, logic [3:0] line, bit is_scan, bit wr);
    m_busy[i] = 1; m_el[i] = 0; m_line[i] = line; m_scan[i] = is_scan; m_wrap[i] = wr;
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (en_n) begin
        model_reset_one(i);
      end else if (m_busy[i] && m_el[i] < dwell[i]) begin
        m_el[i]++;
      end else if (m_busy[i]) begin
        if (mode) begin
          if (m_scan[i]) model_start(i, 4'((m_line[i] + 1) % 16), 1, m_line[i] == 4'd15);
          else           model_start(i, 4'd0, 1, 0);
        end else begin
          m_busy[i] = 0;
        end
      end else if (mode) begin
        model_start(i, 4'd0, 1, 0);
      end else if (code_valid) begin
        model_start(i, code, 0, 0);
      end
    end
  endtask

  task automatic model_reset_one(int i);
    m_el[i] = 0; m_busy[i] = 0; m_scan[i] = 0; m_wrap[i] = 0; m_line[i] = 0;
  endtask

  function automatic logic [15:0] m_out(int i);
    if (m_busy[i] && m_el[i] < dwell[i]) return ~(16'h1 << m_line[i]);
    return 16'hFFFF;
  endfunction

  function automatic bit m_ready(int i);
    return !m_busy[i] && !mode && !en_n;
  endfunction

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are set by the caller just after a falling edge.
  task automatic tick();
    #1;
    for (int i = 0; i < 2; i++) chk($sformatf("ready%0d", i), 32'(d_ready[i]), 32'(m_ready(i)));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("out%0d", i), 32'(d_out[i]), 32'(m_out(i)));
      chk($sformatf("cur%0d", i), 32'(d_cur[i]), 32'(m_line[i]));
      chk($sformatf("wrap%0d", i), 32'(d_wrap[i]), 32'(m_wrap[i] && m_busy[i] && m_el[i] == 0));
      chk($sformatf("onehot%0d", i), 32'($countones(~d_out[i]) <= 1), 32'd1);
    end
  endtask

  function automatic int low_index(logic [15:0] v);
    for (int b = 0; b < 16; b++) if (!v[b]) return b;
    return -1;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         en_n;
    bit         mode;
    bit         valid;
    logic [3:0] code;
    bit         exp_ready;
    logic [15:0] exp_out;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int wraps4, wraps1, guard;
    logic [15:0] prev4;

    tbl[0] = '{0, 0, 1, 4'd9, 1, 16'hFDFF};
    tbl[1] = '{0, 0, 0, 4'd0, 0, 16'hFDFF};
    tbl[2] = '{0, 0, 0, 4'd0, 0, 16'hFDFF};
    tbl[3] = '{0, 0, 0, 4'd0, 0, 16'hFDFF};
    tbl[4] = '{0, 0, 0, 4'd0, 0, 16'hFFFF};
    tbl[5] = '{0, 0, 0, 4'd0, 0, 16'hFFFF};
    tbl[6] = '{0, 0, 0, 4'd0, 1, 16'hFFFF};

    // Reset state
    rst_n = 1'b0; en_n = 1'b0; mode = 1'b0; code = '0; code_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_out", 32'(d_out[i]), 32'hFFFF);
      chk("rst_cur", 32'(d_cur[i]), 32'd0);
      chk("rst_wrap", 32'(d_wrap[i]), 32'd0);
      chk("rst_ready", 32'(d_ready[i]), 32'd1);
    end
    rst_n = 1'b1;

    // Single direct transaction, code 9, dwell 4 instance
    for (int v = 0; v < 7; v++) begin
      en_n = tbl[v].en_n; mode = tbl[v].mode;
      code_valid = tbl[v].valid; code = tbl[v].code;
      #1;
      chk("tbl_ready", 32'(d_ready[0]), 32'(tbl[v].exp_ready));
      tick();
      chk("tbl_out", 32'(d_out[0]), 32'(tbl[v].exp_out));
    end

    // Back-to-back codes 3 then 12 with valid held high
    code_valid = 1'b1; code = 4'd3; prev4 = d_out[0];
    for (int t = 0; t < 30; t++) begin
      if (code_valid && m_ready(0)) exp_q.push_back(code);
      tick();
      if (d_out[0] != 16'hFFFF && prev4 == 16'hFFFF) begin
        if (exp_q.size() == 0) chk("b2b_unexpected", 32'(low_index(d_out[0])), 32'hFFFF);
        else chk("b2b_line", 32'(low_index(d_out[0])), 32'(exp_q.pop_front()));
      end
      prev4 = d_out[0];
      if (code_valid && m_busy[0] && m_el[0] == 0) begin
        if (code == 4'd3) code = 4'd12;
        else code_valid = 1'b0;
      end
    end
    chk("b2b_drain", 32'(exp_q.size()), 32'd0);

    // Scan sweep from idle
    code_valid = 1'b0; en_n = 1'b1;
    repeat (2) tick();
    en_n = 1'b0; mode = 1'b1; wraps4 = 0; wraps1 = 0;
    for (int t = 0; t < 96; t++) begin
      tick();
      if (d_wrap[0]) wraps4++;
      if (d_wrap[1]) wraps1++;
      if (d_wrap[1]) chk("wrap_line0", 32'(d_out[1]), 32'hFFFE);
    end
    chk("wraps_dwell4", 32'(wraps4), 32'd1);
    chk("wraps_dwell1", 32'(wraps1), 32'd2);

    // Async reset mid-scan at line 10 (dwell 4 instance)
    guard = 0;
    while (!(m_busy[0] && m_line[0] == 4'd10 && m_el[0] == 1) && guard < 100) begin
      tick();
      guard++;
    end
    chk("reach_line10", 32'(guard < 100), 32'd1);
    chk("line10_low", 32'(d_out[0]), 32'hFBFF);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      chk("arst_out", 32'(d_out[i]), 32'hFFFF);
      chk("arst_cur", 32'(d_cur[i]), 32'd0);
      chk("arst_wrap", 32'(d_wrap[i]), 32'd0);
    end
    @(negedge clk);
    chk("arst_hold", 32'(d_out[0]), 32'hFFFF);
    rst_n = 1'b1;
    tick();
    chk("post_rst_line0", 32'(d_out[0]), 32'hFFFE);

    // EN_N raised while line 7 held
    mode = 1'b0; en_n = 1'b1;
    tick();
    en_n = 1'b0; code_valid = 1'b1; code = 4'd7;
    tick();
    code_valid = 1'b0;
    repeat (2) tick();
    chk("line7_low", 32'(d_out[0]), 32'hFF7F);
    en_n = 1'b1; code_valid = 1'b1; code = 4'd2;
    #1 chk("en_ready", 32'(d_ready[0]), 32'd0);
    tick();
    chk("en_out", 32'(d_out[0]), 32'hFFFF);
    chk("en_cur", 32'(d_cur[0]), 32'd0);
    repeat (2) tick();
    chk("en_out_hold", 32'(d_out[0]), 32'hFFFF);
    code_valid = 1'b0; en_n = 1'b0;
    tick();

    // mode 0->1 during HOLD of code 5
    code_valid = 1'b1; code = 4'd5;
    tick();
    code_valid = 1'b0; mode = 1'b1;
    repeat (3) tick();
    chk("mt_hold", 32'(d_out[0]), 32'hFFDF);
    tick();
    chk("mt_blank", 32'(d_out[0]), 32'hFFFF);
    tick();
    chk("mt_scan0", 32'(d_out[0]), 32'hFFFE);

    // Randomized traffic against the model
    mode = 1'b0; en_n = 1'b1;
    tick();
    for (int t = 0; t < 400; t++) begin
      en_n       = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      code_valid = $urandom_range(0, 1);
      code       = 4'($urandom_range(0, 15));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
